// File: rtl/mcu_spi_link.sv
// SPI mode-0 slave front end: decodes a leading target byte, strobes payload bytes to the
// selected target and serialises its reply on MISO. Optional partial-byte timeout: MCU_SPI_TIMEOUT_EN.
module mcu_spi_link #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_ss_n,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       data_in_strobe,
    output logic       data_in_start,
    output logic [7:0] data_in,
    output logic [1:0] target,
    output logic       target_valid,
    input  logic [7:0] data_out_sys,
    input  logic [7:0] data_out_hid,
    input  logic [7:0] data_out_sdc,
    input  logic [7:0] data_out_aux
);

    typedef enum logic [1:0] {ST_IDLE, ST_TGT, ST_CMD, ST_DATA} state_t;

    state_t     state;
    logic [1:0] ss_sr, sclk_sr, mosi_sr;
    logic       ss_d, sclk_d;
    logic [1:0] prime;
    logic       armed;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] tx;
    logic       skip_shift;
    logic       done_d1, done_d2, tgt_d1, tgt_d2;

    logic       ss_sync, sclk_sync, mosi_sync;
    logic       sclk_rise, sclk_fall, byte_done;
    logic [7:0] rx_next;
    logic [7:0] load_val;

    assign ss_sync   = ss_sr[1];
    assign sclk_sync = sclk_sr[1];
    assign mosi_sync = mosi_sr[1];
    assign sclk_rise = ~ss_sync & sclk_sync & ~sclk_d;
    assign sclk_fall = ~ss_sync & ~sclk_sync & sclk_d;
    assign byte_done = sclk_rise && (bit_cnt == 3'd7) && (state != ST_IDLE);
    assign rx_next   = {rx_sr, mosi_sync};
    assign spi_miso  = tx[7];

    // Reply after the target byte itself is always zero, as is any reply in an invalid frame.
    always_comb begin
        load_val = 8'h00;
        if (target_valid && !tgt_d2) begin
            case (target)
                2'd0:    load_val = data_out_sys;
                2'd1:    load_val = data_out_hid;
                2'd2:    load_val = data_out_sdc;
                default: load_val = data_out_aux;
            endcase
        end
    end

`ifdef MCU_SPI_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            ss_sr          <= 2'b11;
            sclk_sr        <= 2'b00;
            mosi_sr        <= 2'b00;
            ss_d           <= 1'b1;
            sclk_d         <= 1'b0;
            prime          <= 2'b00;
            armed          <= 1'b0;
            bit_cnt        <= 3'd0;
            rx_sr          <= 7'd0;
            tx             <= 8'h00;
            skip_shift     <= 1'b0;
            done_d1        <= 1'b0;
            done_d2        <= 1'b0;
            tgt_d1         <= 1'b0;
            tgt_d2         <= 1'b0;
            data_in_strobe <= 1'b0;
            data_in_start  <= 1'b0;
            data_in        <= 8'h00;
            target         <= 2'd0;
            target_valid   <= 1'b0;
`ifdef MCU_SPI_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
        end else begin
            ss_sr          <= {ss_sr[0], spi_ss_n};
            sclk_sr        <= {sclk_sr[0], spi_sclk};
            mosi_sr        <= {mosi_sr[0], spi_mosi};
            ss_d           <= ss_sync;
            sclk_d         <= sclk_sync;
            prime          <= {prime[0], 1'b1};
            // Only a select seen high after reset arms the next frame; a frame cut by reset is not resumed.
            armed          <= armed | (prime[1] & ss_sync);
            data_in_strobe <= 1'b0;
            data_in_start  <= 1'b0;
            done_d1        <= byte_done;
            done_d2        <= done_d1;
            tgt_d1         <= (state == ST_TGT);
            tgt_d2         <= tgt_d1;

            if (ss_sync) begin
                state        <= ST_IDLE;
                bit_cnt      <= 3'd0;
                target_valid <= 1'b0;
                tx           <= 8'h00;
                skip_shift   <= 1'b0;
`ifdef MCU_SPI_TIMEOUT_EN
                tmo_cnt      <= '0;
`endif
            end else if (state == ST_IDLE) begin
                if (armed) begin
                    state      <= ST_TGT;
                    bit_cnt    <= 3'd0;
                    tx         <= 8'h00;
                    skip_shift <= 1'b0;
                end
            end else begin
                if (sclk_rise) begin
                    rx_sr   <= rx_next[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end

                if (byte_done) begin
                    case (state)
                        ST_TGT: begin
                            state        <= ST_CMD;
                            target_valid <= (rx_next <= 8'd3);
                            if (rx_next <= 8'd3) target <= rx_next[1:0];
                        end
                        ST_CMD: begin
                            state <= ST_DATA;
                            if (target_valid) begin
                                data_in        <= rx_next;
                                data_in_strobe <= 1'b1;
                                data_in_start  <= 1'b1;
                            end
                        end
                        default: begin
                            if (target_valid) begin
                                data_in        <= rx_next;
                                data_in_strobe <= 1'b1;
                            end
                        end
                    endcase
                end

                // The falling edge that closes the last bit must not shift out the fresh reply's MSB.
                if (done_d2) begin
                    tx         <= load_val;
                    skip_shift <= 1'b1;
                end else if (sclk_fall) begin
                    if (skip_shift) skip_shift <= 1'b0;
                    else            tx         <= {tx[6:0], 1'b0};
                end

`ifdef MCU_SPI_TIMEOUT_EN
                if (sclk_rise || sclk_fall || bit_cnt == 3'd0) begin
                    tmo_cnt <= '0;
                end else if (tmo_cnt == CNT_W'(TIMEOUT)) begin
                    tmo_cnt <= '0;
                    bit_cnt <= 3'd0;
                end else begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_mcu_spi_link.sv
// Scoreboard bench for mcu_spi_link: directed SPI frames, strobes checked by a monitor process.
module tb_mcu_spi_link;

    localparam int unsigned H = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       spi_ss_n = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       data_in_strobe;
    logic       data_in_start;
    logic [7:0] data_in;
    logic [1:0] target;
    logic       target_valid;
    logic [7:0] data_out_sys = 8'h00;
    logic [7:0] data_out_hid = 8'h96;
    logic [7:0] data_out_sdc = 8'hC3;
    logic [7:0] data_out_aux = 8'h3A;

    typedef struct packed {
        logic       start;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic strobe_prev = 1'b0;

    always #5 clk = ~clk;

    mcu_spi_link #(.TIMEOUT(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .spi_ss_n       (spi_ss_n),
        .spi_sclk       (spi_sclk),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .data_in_strobe (data_in_strobe),
        .data_in_start  (data_in_start),
        .data_in        (data_in),
        .target         (target),
        .target_valid   (target_valid),
        .data_out_sys   (data_out_sys),
        .data_out_hid   (data_out_hid),
        .data_out_sdc   (data_out_sdc),
        .data_out_aux   (data_out_aux)
    );

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic expect_strobe(input logic s, input logic [7:0] d);
        exp_t e;
        e.start = s;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every strobe against the scoreboard; sys target replies with ~data_in.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && data_in_strobe) begin
            check8("strobe_width", 8'(strobe_prev), 8'h00);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got data %02h start %0d expected none", data_in, data_in_start);
            end else begin
                e = exp_q.pop_front();
                check8("strobe_start", 8'(data_in_start), 8'(e.start));
                check8("strobe_data", data_in, e.data);
            end
            data_out_sys = ~data_in;
        end
        strobe_prev = data_in_strobe;
    end

    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_mosi = b[7-i];
            repeat (H) @(posedge clk);
            #1;
            r = {r[6:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (H) @(posedge clk);
            #1;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic xfer(input string name, input logic [7:0] b, input logic [7:0] exp_miso);
        logic [7:0] r;
        spi_bits(b, 8, r);
        check8(name, r, exp_miso);
    endtask

    task automatic frame_start();
        @(posedge clk);
        #1 spi_ss_n = 1'b0;
    endtask

    task automatic frame_end();
        repeat (H) @(posedge clk);
        #1 spi_ss_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        repeat (3) @(posedge clk);
        #1;
        check8("rst_strobe", 8'(data_in_strobe), 8'h00);
        check8("rst_start", 8'(data_in_start), 8'h00);
        check8("rst_data_in", data_in, 8'h00);
        check8("rst_target", 8'(target), 8'h00);
        check8("rst_tvalid", 8'(target_valid), 8'h00);
        check8("rst_miso", 8'(spi_miso), 8'h00);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Frame to sys: reply to byte N appears during byte N+1
        expect_strobe(1'b1, 8'h00);
        expect_strobe(1'b0, 8'hAA);
        expect_strobe(1'b0, 8'hAA);
        frame_start();
        xfer("f1_miso0", 8'h00, 8'h00);
        check8("f1_target", 8'(target), 8'h00);
        check8("f1_tvalid", 8'(target_valid), 8'h01);
        xfer("f1_miso1", 8'h00, 8'h00);
        xfer("f1_miso2", 8'hAA, 8'hFF);
        xfer("f1_miso3", 8'hAA, 8'h55);
        frame_end();
        check8("f1_tvalid_end", 8'(target_valid), 8'h00);

        // Frame to sdc: sys reply must be ignored
        expect_strobe(1'b1, 8'h17);
        expect_strobe(1'b0, 8'h55);
        frame_start();
        xfer("f2_miso0", 8'h02, 8'h00);
        check8("f2_target", 8'(target), 8'h02);
        xfer("f2_miso1", 8'h17, 8'h00);
        xfer("f2_miso2", 8'h55, 8'hC3);
        frame_end();

        // Invalid target id: no strobes, all-zero replies
        frame_start();
        xfer("f3_miso0", 8'h07, 8'h00);
        check8("f3_tvalid", 8'(target_valid), 8'h00);
        xfer("f3_miso1", 8'h01, 8'h00);
        xfer("f3_miso2", 8'h02, 8'h00);
        frame_end();

        // Select raised mid-byte, then a clean frame to aux
        frame_start();
        xfer("f4_miso0", 8'h01, 8'h00);
        check8("f4_target", 8'(target), 8'h01);
        spi_bits(8'hA5, 5, r);
        frame_end();
        expect_strobe(1'b1, 8'h44);
        expect_strobe(1'b0, 8'h45);
        frame_start();
        xfer("f5_miso0", 8'h03, 8'h00);
        check8("f5_target", 8'(target), 8'h03);
        check8("f5_tvalid", 8'(target_valid), 8'h01);
        xfer("f5_miso1", 8'h44, 8'h00);
        xfer("f5_miso2", 8'h45, 8'h3A);
        frame_end();

        // Reset mid-byte 2; the interrupted frame must not resume
        expect_strobe(1'b1, 8'h11);
        frame_start();
        xfer("f6_miso0", 8'h00, 8'h00);
        xfer("f6_miso1", 8'h11, 8'h00);
        spi_bits(8'hFF, 4, r);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check8("mid_rst_strobe", 8'(data_in_strobe), 8'h00);
        check8("mid_rst_start", 8'(data_in_start), 8'h00);
        check8("mid_rst_data_in", data_in, 8'h00);
        check8("mid_rst_target", 8'(target), 8'h00);
        check8("mid_rst_tvalid", 8'(target_valid), 8'h00);
        check8("mid_rst_miso", 8'(spi_miso), 8'h00);
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        spi_bits(8'h01, 8, r);
        spi_bits(8'h33, 8, r);
        check8("no_resume_tvalid", 8'(target_valid), 8'h00);
        frame_end();
        expect_strobe(1'b1, 8'h10);
        frame_start();
        xfer("f7_miso0", 8'h01, 8'h00);
        check8("f7_target", 8'(target), 8'h01);
        xfer("f7_miso1", 8'h10, 8'h00);
        frame_end();

`ifdef MCU_SPI_TIMEOUT_EN
        // Partial byte dropped after idle timeout
        expect_strobe(1'b1, 8'h3C);
        frame_start();
        xfer("f8_miso0", 8'h00, 8'h00);
        spi_bits(8'hE0, 3, r);
        repeat (20) @(posedge clk);
        #1;
        xfer("f8_miso1", 8'h3C, 8'h00);
        frame_end();
`endif

        repeat (20) @(posedge clk);
        #1;
        check8("scoreboard_empty", 8'(exp_q.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mcu_spi_link.md
# mcu_spi_link

SPI slave front end between the board MCU and the FPGA-side control targets (sysctrl, HID, SD card, aux).

- **Inbound:** synchronises the MCU's SPI signals into `clk`, assembles bytes, and decodes the leading target byte. It then issues byte strobes with start-of-command flags to the selected target.
- **Outbound:** the selected target's reply byte is serialised back on MISO.
- **Position:** sits directly upstream of sysctrl and drives its `data_in_strobe`/`data_in_start`/`data_in`/`data_out` handshake.

## Interface
- `TIMEOUT`, default 1023: idle `clk` cycles before a partial byte is aborted (only with `MCU_SPI_TIMEOUT_EN`).
- `clk` input 1: system clock, all logic.
- `reset_n` input 1: asynchronous active-low reset.
- `spi_ss_n` input 1: MCU chip select, active low, asynchronous to `clk`.
- `spi_sclk` input 1: SPI clock, mode 0, asynchronous to `clk`.
- `spi_mosi` input 1: MCU→FPGA data, MSB first.
- `spi_miso` output 1: FPGA→MCU data, MSB first.
- `data_in_strobe` output 1: one-cycle pulse, payload byte valid.
- `data_in_start` output 1: qualifies strobe; high on first payload byte (command byte).
- `data_in` output 8: payload byte, held until next strobe.
- `target` output 2: target id latched from byte 0 (0=sys, 1=hid, 2=sdc, 3=aux).
- `target_valid` output 1: high while a frame with valid target id is open.
- `data_out_sys`, `data_out_hid`, `data_out_sdc`, `data_out_aux` input 8 each: reply bytes from targets.

## Operation
- **Synchronisation:** `spi_ss_n`, `spi_sclk` and `spi_mosi` each pass through two flip-flops, then one edge-detect register. Rising and falling SCLK edges are detected only while the synchronised `ss_n` is 0.
- **Frame states:**
  - IDLE: `ss_n`=1.
  - TGT: `ss_n` falls; bit counter=0, tx register=0x00.
  - CMD: entered after byte 0 completes.
  - DATA: entered after byte 1.
  - Any `ss_n` rise returns to IDLE, discards the partial byte and clears `target_valid`.
- **Receive:** on each SCLK rising edge, shift the synchronised MOSI into the rx register and increment the 3-bit counter. Counter wrap 7→0 completes a byte.
- **Byte 0:** if the value is ≤3, latch it into `target` and set `target_valid`. If the value is >3, set `target_valid`=0 and suppress all strobes for the frame; the frame must still be tracked until `ss_n` rises.
- **Byte 1:** `data_in`=byte, `data_in_strobe`=1, `data_in_start`=1 (only if `target_valid`).
- **Byte ≥2:** strobe with `data_in_start`=0. There is no byte-count limit.
- **Transmit:** `spi_miso` = tx[7]. The tx register shifts left with 0 fill on each SCLK falling edge except the first falling edge after a byte-load.
  - Two `clk` cycles after every completed byte, tx is loaded with the selected target's `data_out_*`, or 0x00 if `!target_valid` or the frame is in TGT state.
  - The MCU therefore receives the reply to byte N during byte N+1.
- **Reset:** `spi_miso`=0, `data_in_strobe`=0, `data_in_start`=0, `data_in`=0x00, `target`=0, `target_valid`=0, state=IDLE, counter=0, synchronisers=idle (`ss_n`=1, `sclk`=0).
- **Reset mid-frame:** state returns to IDLE. With `reset_n` high again, the logic waits for the next `ss_n` falling edge; a frame already in progress is not resumed.
- **Simultaneous events:** an `ss_n` rise in the same cycle as the 8th rising edge means the byte does not complete and no strobe is issued.

## Timing
- Latency from the 8th synchronised SCLK rising edge to the `data_in_strobe` cycle is 1 `clk`. The strobe is exactly 1 cycle wide.
- Worst-case pin-to-strobe latency is 4 `clk` cycles.
- The tx load occurs 2 `clk` after the strobe, so targets must register `data_out` within 1 cycle of the strobe.
- SCLK high and low phases must each be ≥4 `clk`, i.e. SCLK period ≥8 `clk`.
- `ss_n` must be high for ≥4 `clk` between frames.
- `spi_miso` changes ≤4 `clk` after the SCLK falling edge at the pin.

## Configuration
- `MCU_SPI_TIMEOUT_EN` defined:
  - A counter runs while the bit counter ≠0 and no SCLK edge occurs. It resets on every edge.
  - When it reaches `TIMEOUT`, the bit counter clears and the partial byte is dropped with no strobe. The frame state is kept.
- `MCU_SPI_TIMEOUT_EN` undefined: there is no counter, and a partial byte persists until the next edge or until `ss_n` rises.

## Test plan
- Frame 0x00,0x00,0xAA,0xAA: strobes (start=1,0x00), (start=0,0xAA), (start=0,0xAA). `target`=0. MISO bytes 0x00,0x00, then `data_out_sys` of the byte-1 reply, then the byte-2 reply.
- Frame 0x02,0x17,0x55 with `data_out_sdc`=0xC3: `target`=2, strobes 0x17 (start=1) and 0x55. MISO byte 2 = 0xC3; `data_out_sys` is ignored.
- Frame 0x07,0x01,0x02: no strobes, `target_valid`=0, MISO all 0x00.
- `ss_n` raised after 5 bits of byte 1: no strobe. The next frame's byte 0 decodes correctly and the bit counter restarts at 0.
- `reset_n` asserted mid-byte 2: all outputs are at reset values within 1 cycle. After release, a new frame 0x01,0x10 gives `target`=1 and a strobe of 0x10 with start=1.
- With `MCU_SPI_TIMEOUT_EN` and `TIMEOUT`=16: 3 bits, then 20 idle cycles, then 8 bits of 0x3C gives exactly one strobe, of 0x3C.
